// File: rtl/williams2_pkg.sv
// Shared types and defaults for the williams2 ROM download path.
// Region map, write payload bundle and loader FSM states.
package williams2_pkg;

    typedef enum logic [1:0] {
        REG_PROG,
        REG_SND,
        REG_GFX,
        REG_PROM
    } rom_region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD,
        ST_RUN
    } ld_state_t;

    typedef struct packed {
        rom_region_t region;
        logic [16:0] addr;
        logic [7:0]  data;
    } rom_wr_t;

    localparam logic [7:0]  ROM_INDEX     = 8'd0;
    localparam logic [16:0] DEF_SND_BASE  = 17'h0C000;
    localparam logic [16:0] DEF_GFX_BASE  = 17'h0E000;
    localparam logic [16:0] DEF_PROM_BASE = 17'h1A000;
    localparam logic [16:0] DEF_ROM_END   = 17'h1A400;
    localparam int          DEF_HOLD_CYC  = 16;

endpackage

// File: rtl/rom_skid_buf.sv
// Output register plus one-entry skid buffer for ROM writes.
// Upstream ready drops only when the skid entry is occupied.
module rom_skid_buf
    import williams2_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    i_s_valid,
    output logic    o_s_ready,
    input  rom_wr_t i_s_data,
    output logic    o_m_valid,
    input  logic    i_m_ready,
    output rom_wr_t o_m_data
);

    logic    r_out_v;
    logic    r_skid_v;
    rom_wr_t r_out;
    rom_wr_t r_skid;
    logic    w_in_fire;
    logic    w_out_fire;

    assign w_in_fire  = i_s_valid && !r_skid_v;
    assign w_out_fire = r_out_v && i_m_ready;

    // Move skid entry forward on acceptance; park new data in skid on stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_out    <= '0;
            r_skid   <= '0;
        end else if (w_out_fire) begin
            if (r_skid_v) begin
                r_out    <= r_skid;
                r_skid_v <= 1'b0;
            end else if (w_in_fire) begin
                r_out <= i_s_data;
            end else begin
                r_out_v <= 1'b0;
            end
        end else if (!r_out_v) begin
            if (w_in_fire) begin
                r_out   <= i_s_data;
                r_out_v <= 1'b1;
            end
        end else if (w_in_fire) begin
            r_skid   <= i_s_data;
            r_skid_v <= 1'b1;
        end
    end

    assign o_s_ready = !r_skid_v;
    assign o_m_valid = r_out_v;
    assign o_m_data  = r_out;

endmodule

// File: rtl/williams2_rom_loader.sv
// Bridges the hps_io ioctl download port to the williams2 ROM write port.
// Decodes regions, holds the game in reset and tracks load size/checksum.
module williams2_rom_loader
    import williams2_pkg::*;
#(
    parameter logic [16:0] SND_BASE  = DEF_SND_BASE,
    parameter logic [16:0] GFX_BASE  = DEF_GFX_BASE,
    parameter logic [16:0] PROM_BASE = DEF_PROM_BASE,
    parameter logic [16:0] ROM_END   = DEF_ROM_END,
    parameter int          HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [16:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        rom_ready,
    output logic        rom_wr,
    output logic [1:0]  rom_region,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_do,
    output logic        hold_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  checksum
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);

    ld_state_t   r_state;
    ld_state_t   w_state_nxt;
    logic [16:0] r_count;
    logic [7:0]  r_csum;
    logic        r_err;
    logic        r_done;
    logic [15:0] r_hold;

    logic        w_start;
    logic        w_load_start;
    logic        w_drain_done;
    logic        w_hold_done;
    logic        w_in_range;
    logic        w_accept;
    logic        w_oob;
    logic        w_empty;
    logic        w_s_ready;
    logic        w_m_valid;
    rom_wr_t     w_pay;
    rom_wr_t     w_m_data;

    assign w_start    = ioctl_download && (ioctl_index == ROM_INDEX);
    assign w_in_range = ioctl_addr < ROM_END;
    assign w_accept   = (r_state == ST_LOAD) && ioctl_wr
                        && w_in_range && w_s_ready;
    assign w_oob      = (r_state == ST_LOAD) && ioctl_wr && !w_in_range;
    assign w_empty    = (!w_m_valid || rom_ready) && w_s_ready;

    // Pick the highest region whose base is at or below the address.
    always_comb begin
        w_pay      = '0;
        w_pay.data = ioctl_dout;
        if (ioctl_addr >= PROM_BASE) begin
            w_pay.region = REG_PROM;
            w_pay.addr   = ioctl_addr - PROM_BASE;
        end else if (ioctl_addr >= GFX_BASE) begin
            w_pay.region = REG_GFX;
            w_pay.addr   = ioctl_addr - GFX_BASE;
        end else if (ioctl_addr >= SND_BASE) begin
            w_pay.region = REG_SND;
            w_pay.addr   = ioctl_addr - SND_BASE;
        end else begin
            w_pay.region = REG_PROG;
            w_pay.addr   = ioctl_addr;
        end
    end

    rom_skid_buf u_skid (
        .clk       (clk_sys),
        .reset_n   (reset_n),
        .i_s_valid (w_accept),
        .o_s_ready (w_s_ready),
        .i_s_data  (w_pay),
        .o_m_valid (w_m_valid),
        .i_m_ready (rom_ready),
        .o_m_data  (w_m_data)
    );

    // Next-state logic; a new index-0 download restarts from IDLE/HOLD/RUN.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_start = 1'b0;
        w_drain_done = 1'b0;
        w_hold_done  = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_load_start = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_load_start = 1'b1;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_hold_done = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt  = ST_HOLD;
                    w_drain_done = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, byte count, checksum and status flags.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_csum  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_start) begin
                r_count <= '0;
                r_csum  <= '0;
                r_err   <= 1'b0;
                if (r_state == ST_HOLD) begin
                    r_done <= 1'b0;
                end
            end else begin
                if (w_accept) begin
                    r_csum <= r_csum + ioctl_dout;
                    if (r_count != 17'h1FFFF) begin
                        r_count <= r_count + 17'd1;
                    end
                end
                if (w_oob || (w_drain_done && (r_count != ROM_END))) begin
                    r_err <= 1'b1;
                end
                if (w_hold_done) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Count cycles spent in HOLD; restarts on every entry.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || (r_state != ST_HOLD)) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + 16'd1;
        end
    end

    assign ioctl_wait = !w_s_ready;
    assign rom_wr     = w_m_valid;
    assign rom_region = w_m_data.region;
    assign rom_addr   = w_m_data.addr;
    assign rom_do     = w_m_data.data;
    assign hold_reset = (r_state != ST_RUN);
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign checksum   = r_csum;

endmodule
